// File: rtl/seq_pkg.sv
// Shared constants and state encoding for the sequence serializer / detector path.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } ser_state_e;

    localparam int DEFAULT_SEQ_LEN = 64;

    // Bit-index width; one extra bit keeps SEQ_LEN itself representable.
    function automatic int idx_width(input int len);
        return $clog2(len) + 1;
    endfunction

endpackage

// File: rtl/shift_reg_piso.sv
// Parallel-in, serial-out shift register; dout is always the current MSB.
module shift_reg_piso #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] shift_q, shift_d;

    always_comb begin
        shift_d = shift_q;
        if (load_en) begin
            shift_d = din;
        end else if (shift_en) begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= INIT;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign dout = shift_q[WIDTH-1];

endmodule

// File: rtl/seq_serializer.sv
// Moore FSM that streams a held sequence MSB first onto x for the sequence detector.
// Optional back-to-back replay is enabled by defining SEQ_SERIALIZER_REPEAT_EN.
module seq_serializer
    import seq_pkg::*;
#(
    parameter int                 SEQ_LEN  = DEFAULT_SEQ_LEN,
    parameter logic [SEQ_LEN-1:0] INIT_SEQ = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [SEQ_LEN-1:0]            seq_in,
    input  logic                          start,
`ifdef SEQ_SERIALIZER_REPEAT_EN
    // "repeat" is a reserved word, hence the suffix.
    input  logic                          repeat_en,
`endif
    output logic                          x,
    output logic                          valid,
    output logic                          busy,
    output logic                          done,
    output logic [idx_width(SEQ_LEN)-1:0] bit_idx
);

    localparam int IDX_W = idx_width(SEQ_LEN);

    ser_state_e         state_q, state_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [SEQ_LEN-1:0] hold_q, hold_d;

    logic               shift_load;
    logic               shift_en;
    logic [SEQ_LEN-1:0] shift_din;
    logic               shift_msb;
    logic               last_bit;

    assign last_bit = (bit_idx_q == IDX_W'(SEQ_LEN - 1));

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        hold_d     = hold_q;
        shift_load = 1'b0;
        shift_en   = 1'b0;
        shift_din  = hold_q;

        case (state_q)
            IDLE: begin
                if (load) begin
                    hold_d     = seq_in;
                    shift_load = 1'b1;
                    shift_din  = seq_in;
                end
                // A same-cycle load wins, so the fresh value is what gets streamed.
                if (start) begin
                    state_d    = SHIFT;
                    bit_idx_d  = '0;
                    shift_load = 1'b1;
                    shift_din  = load ? seq_in : hold_q;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    bit_idx_d = '0;
`ifdef SEQ_SERIALIZER_REPEAT_EN
                    if (repeat_en) begin
                        shift_load = 1'b1;
                        shift_din  = hold_q;
                    end else begin
                        state_d = DONE;
                    end
`else
                    state_d = DONE;
`endif
                end else begin
                    bit_idx_d = bit_idx_q + 1'b1;
                    shift_en  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                bit_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            hold_q    <= INIT_SEQ;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            hold_q    <= hold_d;
        end
    end

    shift_reg_piso #(
        .WIDTH (SEQ_LEN),
        .INIT  (INIT_SEQ)
    ) u_piso (
        .clk      (clk),
        .rst      (rst),
        .load_en  (shift_load),
        .shift_en (shift_en),
        .din      (shift_din),
        .dout     (shift_msb)
    );

    // Outputs decode registered state only.
    assign valid   = (state_q == SHIFT);
    assign busy    = (state_q == SHIFT);
    assign done    = (state_q == DONE);
    assign x       = valid & shift_msb;
    assign bit_idx = valid ? bit_idx_q : '0;

endmodule

// File: tb/tb_seq_serializer.sv
// Scoreboard bench: an 8-bit instance under directed + random traffic, and a
// 64-bit instance replaying its reset sequence.
module tb_seq_serializer;

    localparam logic [7:0]  INIT8  = 8'h5A;
    localparam logic [63:0] INIT64 = 64'h18330C1830C30C30;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       load8 = 1'b0, start8 = 1'b0;
    logic [7:0] seq_in8 = '0;
    logic       x8, valid8, busy8, done8;
    logic [3:0] idx8;
`ifdef SEQ_SERIALIZER_REPEAT_EN
    logic       rpt8 = 1'b0;
    logic       rpt64 = 1'b0;
`endif

    logic        load64 = 1'b0, start64 = 1'b0;
    logic [63:0] seq_in64 = '0;
    logic        x64, valid64, busy64, done64;
    logic [6:0]  idx64;

    int tests = 0;
    int fails = 0;

    // Expected output stream: idx*2+bit for a data cycle, -1 for the done pulse.
    int q8[$];
    int q64[$];
    logic [7:0] hold8 = INIT8;
    bit pend8 = 1'b0, pend64 = 1'b0;

    always #5 clk = ~clk;

    seq_serializer #(.SEQ_LEN(8), .INIT_SEQ(INIT8)) u_dut8 (
        .clk(clk), .rst(rst), .load(load8), .seq_in(seq_in8), .start(start8),
`ifdef SEQ_SERIALIZER_REPEAT_EN
        .repeat_en(rpt8),
`endif
        .x(x8), .valid(valid8), .busy(busy8), .done(done8), .bit_idx(idx8)
    );

    seq_serializer #(.SEQ_LEN(64), .INIT_SEQ(INIT64)) u_dut64 (
        .clk(clk), .rst(rst), .load(load64), .seq_in(seq_in64), .start(start64),
`ifdef SEQ_SERIALIZER_REPEAT_EN
        .repeat_en(rpt64),
`endif
        .x(x64), .valid(valid64), .busy(busy64), .done(done64), .bit_idx(idx64)
    );

    task automatic push_run8();
        for (int i = 7; i >= 0; i--) q8.push_back((7 - i) * 2 + int'(hold8[i]));
        q8.push_back(-1);
    endtask

    task automatic push_run64();
        for (int i = 63; i >= 0; i--) q64.push_back((63 - i) * 2 + int'(INIT64[i]));
        q64.push_back(-1);
    endtask

    // Drive one cycle of inputs; the model only reacts while no run is pending.
    task automatic cycle(input logic l, input logic s, input logic [7:0] d);
        load8 = l; start8 = s; seq_in8 = d;
        if (q8.size() == 0) begin
            if (l) hold8 = d;
            if (s) push_run8();
        end
`ifdef SEQ_SERIALIZER_REPEAT_EN
        else if (rpt8 && q8.size() == 2 && q8[1] == -1) begin
            void'(q8.pop_back());
            push_run8();
        end
`endif
        if (start64 && q64.size() == 0) push_run64();
        @(posedge clk); #1;
        load8 = 1'b0; start8 = 1'b0; seq_in8 = '0;
    endtask

    task automatic do_reset(input int n);
        load8 = 1'b0; start8 = 1'b0; start64 = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        q8.delete(); q64.delete();
        hold8 = INIT8;
        repeat (n - 1) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q8.size() != 0 || q64.size() != 0) && n < 300) begin
            cycle(1'b0, 1'b0, 8'h00);
            n++;
        end
        tests++;
        if (q8.size() != 0 || q64.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout pending8=%0d pending64=%0d required 0", q8.size(), q64.size());
        end
    endtask

    always @(negedge clk) begin
        int e;
        tests++;
        if (valid8) begin
            if (q8.size() == 0) begin
                fails++;
                $display("FAIL d8_unexpected_valid x=%b idx=%0d required no output", x8, idx8);
            end else begin
                e = q8.pop_front();
                if (e < 0 || x8 !== e[0] || idx8 !== 4'(e >> 1) || busy8 !== 1'b1 || done8 !== 1'b0) begin
                    fails++;
                    $display("FAIL d8_bit got x=%b idx=%0d busy=%b done=%b required code=%0d (x=%0d idx=%0d)",
                             x8, idx8, busy8, done8, e, e & 1, e >>> 1);
                end
            end
        end else if (done8) begin
            if (q8.size() == 0 || q8[0] != -1 || x8 !== 1'b0 || busy8 !== 1'b0 || idx8 !== 4'd0) begin
                fails++;
                $display("FAIL d8_done got done=1 x=%b busy=%b idx=%0d required pending=-1 (have %0d entries)",
                         x8, busy8, idx8, q8.size());
            end else begin
                void'(q8.pop_front());
                $display("[TB] d8 run complete");
            end
        end else begin
            if (x8 !== 1'b0 || busy8 !== 1'b0 || idx8 !== 4'd0 || done8 !== 1'b0) begin
                fails++;
                $display("FAIL d8_idle got x=%b busy=%b idx=%0d done=%b required all 0", x8, busy8, idx8, done8);
            end else if (pend8 && q8.size() != 0) begin
                fails++;
                $display("FAIL d8_gap got valid=0 required code=%0d", q8[0]);
            end
        end
        pend8 = (q8.size() != 0);

        tests++;
        if (valid64) begin
            if (q64.size() == 0) begin
                fails++;
                $display("FAIL d64_unexpected_valid x=%b idx=%0d required no output", x64, idx64);
            end else begin
                e = q64.pop_front();
                if (e < 0 || x64 !== e[0] || idx64 !== 7'(e >> 1) || busy64 !== 1'b1) begin
                    fails++;
                    $display("FAIL d64_bit got x=%b idx=%0d busy=%b required code=%0d (x=%0d idx=%0d)",
                             x64, idx64, busy64, e, e & 1, e >>> 1);
                end
            end
        end else if (done64) begin
            if (q64.size() == 0 || q64[0] != -1) begin
                fails++;
                $display("FAIL d64_done got done=1 required pending=-1 (have %0d entries)", q64.size());
            end else begin
                void'(q64.pop_front());
                $display("[TB] d64 run complete");
            end
        end else begin
            if (x64 !== 1'b0 || busy64 !== 1'b0 || idx64 !== 7'd0) begin
                fails++;
                $display("FAIL d64_idle got x=%b busy=%b idx=%0d required all 0", x64, busy64, idx64);
            end else if (pend64 && q64.size() != 0) begin
                fails++;
                $display("FAIL d64_gap got valid=0 required code=%0d", q64[0]);
            end
        end
        pend64 = (q64.size() != 0);
    end

    initial begin
        #1;
        do_reset(2);
        repeat (5) cycle(1'b0, 1'b0, 8'h00);

        // Two replays of the 64-bit reset sequence with no load.
        start64 = 1'b1; cycle(1'b0, 1'b0, 8'h00); start64 = 1'b0;
        wait_idle();
        start64 = 1'b1; cycle(1'b0, 1'b0, 8'h00); start64 = 1'b0;
        wait_idle();

        cycle(1'b1, 1'b0, 8'b10110001);
        cycle(1'b0, 1'b1, 8'h00);
        wait_idle();

        cycle(1'b1, 1'b1, 8'hF0);
        wait_idle();
        cycle(1'b0, 1'b1, 8'h00);
        wait_idle();

        // Load ignored mid-run at bit 3, reset at bit 5.
        cycle(1'b1, 1'b1, 8'hB3);
        repeat (3) cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        do_reset(1);
        repeat (3) cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
        wait_idle();

`ifdef SEQ_SERIALIZER_REPEAT_EN
        rpt8 = 1'b1;
        cycle(1'b1, 1'b1, 8'hA5);
        repeat (16) cycle(1'b0, 1'b0, 8'h00);
        rpt8 = 1'b0;
        wait_idle();
`endif

        for (int i = 0; i < 400; i++) begin
`ifdef SEQ_SERIALIZER_REPEAT_EN
            rpt8 = ($urandom_range(0, 3) == 0);
`endif
            if ($urandom_range(0, 120) == 0) begin
                do_reset(1 + $urandom_range(0, 1));
            end else begin
                cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, 8'($urandom));
            end
        end
`ifdef SEQ_SERIALIZER_REPEAT_EN
        rpt8 = 1'b0;
`endif
        wait_idle();
        repeat (2) cycle(1'b0, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
